game_sequencer: RTL and testbench

- Top-level game-flow controller that sequences the player ship, invader grid and bullet datapaths through attract, play, hit-pause, level-clear and game-over phases.
- Owns the level number, score and high score.
- Issues single-cycle control pulses (new game, level respawn, extra life) and a run enable that freezes all motion outside active play.
- Sits between the debounced buttons and the player and enemy blocks.

---
 rtl/game_pkg.sv | 27 ++
 rtl/score_keeper.sv | 53 +++++
 rtl/game_sequencer.sv | 139 +++++++++++++
 tb/tb_game_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller: one-hot phase
// encoding, banner codes and the level-advance helper.
package game_pkg;

  localparam int SCORE_W = 16;

  typedef enum logic [4:0] {
    ST_ATTRACT     = 5'b00001,
    ST_PLAY        = 5'b00010,
    ST_HIT_PAUSE   = 5'b00100,
    ST_LEVEL_CLEAR = 5'b01000,
    ST_GAME_OVER   = 5'b10000
  } state_e;

  localparam logic [2:0] BANNER_NONE     = 3'd0;
  localparam logic [2:0] BANNER_TITLE    = 3'd1;
  localparam logic [2:0] BANNER_PAUSED   = 3'd2;
  localparam logic [2:0] BANNER_CLEAR    = 3'd3;
  localparam logic [2:0] BANNER_GAMEOVER = 3'd4;

  // Past the last level play wraps back to level 1.
  function automatic logic [3:0] next_level(input logic [3:0] lvl,
                                            input logic [3:0] max_lvl);
    return (lvl >= max_lvl) ? 4'd1 : lvl + 4'd1;
  endfunction

endpackage

// File: rtl/score_keeper.sv
// Saturating score accumulator with clear-on-new-game and a high-score
// register that tracks the score while the game-over phase is shown.
module score_keeper
  import game_pkg::*;
#(
  parameter int score_width_p = SCORE_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     add_i,
  input  logic [3:0]               points_i,
  input  logic                     track_hi_i,
  output logic [score_width_p-1:0] score_o,
  output logic [score_width_p-1:0] hiscore_o
);

  logic [score_width_p-1:0] score_q, score_d;
  logic [score_width_p-1:0] hiscore_q, hiscore_d;
  logic [score_width_p:0]   sum;

  always_comb begin
    sum = {1'b0, score_q} + {{(score_width_p-3){1'b0}}, points_i};
    score_d = score_q;
    if (clear_i) begin
      score_d = '0;
    end else if (add_i) begin
      // A carry out of the top bit pins the score at all-ones.
      score_d = sum[score_width_p] ? {score_width_p{1'b1}} : sum[score_width_p-1:0];
    end
  end

  always_comb begin
    hiscore_d = hiscore_q;
    if (track_hi_i && (score_q > hiscore_q)) begin
      hiscore_d = score_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      score_q   <= '0;
      hiscore_q <= '0;
    end else begin
      score_q   <= score_d;
      hiscore_q <= hiscore_d;
    end
  end

  assign score_o   = score_q;
  assign hiscore_o = hiscore_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences attract, play, hit-pause, level-clear and
// game-over phases, owns level and frame counters, and issues control pulses.
module game_sequencer
  import game_pkg::*;
#(
  parameter logic [3:0] num_levels_p   = 4'd8,
  parameter int         pause_frames_p = 60,
  parameter int         score_width_p  = SCORE_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_tick_i,
  input  logic                     start_i,
  input  logic                     player_hit_i,
  input  logic                     player_alive_i,
  input  logic                     enemies_cleared_i,
  input  logic                     enemies_landed_i,
  input  logic                     kill_i,
  input  logic [3:0]               kill_points_i,
  output logic [4:0]               state_o,
  output logic                     run_o,
  output logic [3:0]               level_o,
  output logic [score_width_p-1:0] score_o,
  output logic [score_width_p-1:0] hiscore_o,
  output logic [2:0]               banner_o,
  output logic                     new_game_o,
  output logic                     level_reset_o,
  output logic                     add_life_o
);

  localparam int CNT_W = $clog2(pause_frames_p + 1);

  state_e             state_q, state_d;
  logic [3:0]         level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               new_game_q, new_game_d;
  logic               level_reset_q, level_reset_d;
  logic               add_life_q, add_life_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_ATTRACT;
      level_q       <= 4'd1;
      cnt_q         <= '0;
      new_game_q    <= 1'b0;
      level_reset_q <= 1'b0;
      add_life_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      new_game_q    <= new_game_d;
      level_reset_q <= level_reset_d;
      add_life_q    <= add_life_d;
    end
  end

  // Transition actions are computed alongside the next state so every pulse
  // lands in the first cycle the new state is visible.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    cnt_d         = cnt_q;
    new_game_d    = 1'b0;
    level_reset_d = 1'b0;
    add_life_d    = 1'b0;
    case (state_q)
      ST_ATTRACT, ST_GAME_OVER: begin
        if (start_i) begin
          state_d       = ST_PLAY;
          level_d       = 4'd1;
          new_game_d    = 1'b1;
          level_reset_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (enemies_landed_i || (player_hit_i && !player_alive_i)) begin
          state_d = ST_GAME_OVER;
        end else if (player_hit_i) begin
          state_d = ST_HIT_PAUSE;
        end else if (enemies_cleared_i) begin
          state_d    = ST_LEVEL_CLEAR;
          cnt_d      = CNT_W'(pause_frames_p);
          add_life_d = ~level_q[0];
        end
      end
      ST_HIT_PAUSE: begin
        if (start_i) begin
          state_d = ST_PLAY;
        end
      end
      ST_LEVEL_CLEAR: begin
        if (frame_tick_i) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d       = ST_PLAY;
            level_d       = next_level(level_q, num_levels_p);
            level_reset_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_ATTRACT;
    endcase
  end

  always_comb begin
    run_o    = 1'b0;
    banner_o = BANNER_NONE;
    case (state_q)
      ST_ATTRACT:     banner_o = BANNER_TITLE;
      ST_PLAY:        run_o    = 1'b1;
      ST_HIT_PAUSE:   banner_o = BANNER_PAUSED;
      ST_LEVEL_CLEAR: banner_o = BANNER_CLEAR;
      ST_GAME_OVER:   banner_o = BANNER_GAMEOVER;
      default:        banner_o = BANNER_NONE;
    endcase
  end

  score_keeper #(
    .score_width_p(score_width_p)
  ) u_score (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (new_game_d),
    .add_i     (kill_i && (state_q == ST_PLAY)),
    .points_i  (kill_points_i),
    .track_hi_i(state_q == ST_GAME_OVER),
    .score_o   (score_o),
    .hiscore_o (hiscore_o)
  );

  assign state_o       = state_q;
  assign level_o       = level_q;
  assign new_game_o    = new_game_q;
  assign level_reset_o = level_reset_q;
  assign add_life_o    = add_life_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus random
// stimulus, all checked every cycle against a phase-level reference model.
module tb_game_sequencer;

  localparam int NLEV  = 8;
  localparam int PAUSE = 60;
  localparam int SMAX  = 65535;

  localparam int M_ATTRACT = 0, M_PLAY = 1, M_HIT = 2, M_CLEAR = 3, M_OVER = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        frame_tick_i = 1'b0, start_i = 1'b0, player_hit_i = 1'b0;
  logic        player_alive_i = 1'b1, enemies_cleared_i = 1'b0, enemies_landed_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [3:0]  kill_points_i = 4'd0;
  logic [4:0]  state_o;
  logic        run_o, new_game_o, level_reset_o, add_life_o;
  logic [3:0]  level_o;
  logic [15:0] score_o, hiscore_o;
  logic [2:0]  banner_o;

  game_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .frame_tick_i(frame_tick_i),
    .start_i(start_i), .player_hit_i(player_hit_i), .player_alive_i(player_alive_i),
    .enemies_cleared_i(enemies_cleared_i), .enemies_landed_i(enemies_landed_i),
    .kill_i(kill_i), .kill_points_i(kill_points_i), .state_o(state_o),
    .run_o(run_o), .level_o(level_o), .score_o(score_o), .hiscore_o(hiscore_o),
    .banner_o(banner_o), .new_game_o(new_game_o), .level_reset_o(level_reset_o),
    .add_life_o(add_life_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: phase, counters and expected pulses as plain integers.
  int m_ph, m_level, m_score, m_hi, m_cnt;
  bit m_ng, m_lr, m_al;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_ATTRACT; m_level = 1; m_score = 0; m_hi = 0; m_cnt = 0;
    m_ng = 0; m_lr = 0; m_al = 0;
  endtask

  task automatic start_game();
    m_ph = M_PLAY; m_ng = 1; m_lr = 1; m_level = 1; m_score = 0;
  endtask

  task automatic model_step();
    int ph;
    ph = m_ph;
    m_ng = 0; m_lr = 0; m_al = 0;
    if (ph == M_OVER && m_score > m_hi) m_hi = m_score;
    if (ph == M_PLAY && kill_i) begin
      m_score = m_score + int'(kill_points_i);
      if (m_score > SMAX) m_score = SMAX;
    end
    case (ph)
      M_ATTRACT, M_OVER: if (start_i) start_game();
      M_PLAY: begin
        if (enemies_landed_i || (player_hit_i && !player_alive_i)) m_ph = M_OVER;
        else if (player_hit_i) m_ph = M_HIT;
        else if (enemies_cleared_i) begin
          m_ph = M_CLEAR; m_cnt = PAUSE; m_al = (m_level % 2 == 0);
        end
      end
      M_HIT: if (start_i) m_ph = M_PLAY;
      default: begin
        if (frame_tick_i) begin
          if (m_cnt == 1) begin
            m_ph = M_PLAY; m_lr = 1;
            m_level = (m_level == NLEV) ? 1 : m_level + 1;
          end else m_cnt--;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    int ban;
    case (m_ph)
      M_ATTRACT: ban = 1;
      M_PLAY:    ban = 0;
      M_HIT:     ban = 2;
      M_CLEAR:   ban = 3;
      default:   ban = 4;
    endcase
    check("state",       32'(state_o),       32'(1 << m_ph));
    check("run",         32'(run_o),         32'(m_ph == M_PLAY));
    check("banner",      32'(banner_o),      32'(ban));
    check("level",       32'(level_o),       32'(m_level));
    check("score",       32'(score_o),       32'(m_score));
    check("hiscore",     32'(hiscore_o),     32'(m_hi));
    check("new_game",    32'(new_game_o),    32'(m_ng));
    check("level_reset", 32'(level_reset_o), 32'(m_lr));
    check("add_life",    32'(add_life_o),    32'(m_al));
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
    compare_all();
    frame_tick_i = 0; start_i = 0; player_hit_i = 0; player_alive_i = 1;
    enemies_cleared_i = 0; enemies_landed_i = 0; kill_i = 0; kill_points_i = 0;
  endtask

  task automatic kill(input logic [3:0] pts);
    kill_i = 1; kill_points_i = pts; step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick_i = 1; step();
      step();
    end
  endtask

  task automatic clear_level();
    enemies_cleared_i = 1; step();
    ticks(PAUSE);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    reset_i = 0;
    step();

    start_i = 1; step();
    check("start_state", 32'(state_o), 32'h02);
    check("start_ng", 32'(new_game_o), 32'd1);
    step();

    for (int i = 0; i < 3; i++) kill(4'd10);
    check("score30", 32'(score_o), 32'd30);

    enemies_cleared_i = 1; step();
    ticks(PAUSE - 1);
    check("clear59", 32'(state_o), 32'h08);
    ticks(1);
    check("level2", 32'(level_o), 32'd2);

    enemies_cleared_i = 1; step();
    check("addlife", 32'(add_life_o), 32'd1);
    ticks(PAUSE);
    check("level3", 32'(level_o), 32'd3);

    player_hit_i = 1; player_alive_i = 1; enemies_cleared_i = 1; step();
    check("hitpause", 32'(banner_o), 32'd2);
    start_i = 1; step();
    step();

    for (int i = 0; i < 9; i++) kill(4'd10);
    check("score120", 32'(score_o), 32'd120);
    player_hit_i = 1; player_alive_i = 0; step();
    step();
    check("hi120", 32'(hiscore_o), 32'd120);
    start_i = 1; step();
    check("newgame_score", 32'(score_o), 32'd0);

    for (int l = 0; l < NLEV; l++) clear_level();
    check("wrap", 32'(level_o), 32'd1);

    for (int i = 0; i < 4368; i++) kill(4'd15);
    kill(4'd10);
    check("preload", 32'(score_o), 32'hFFFA);
    kill(4'd10);
    check("saturate", 32'(score_o), 32'hFFFF);

    for (int i = 0; i < 3000; i++) begin
      start_i           = ($urandom_range(0, 19) == 0);
      player_hit_i      = ($urandom_range(0, 39) == 0);
      player_alive_i    = ($urandom_range(0, 3) != 0);
      enemies_cleared_i = ($urandom_range(0, 29) == 0);
      enemies_landed_i  = ($urandom_range(0, 149) == 0);
      kill_i            = ($urandom_range(0, 2) == 0);
      kill_points_i     = 4'($urandom_range(0, 15));
      frame_tick_i      = $urandom_range(0, 1);
      step();
    end

    for (int i = 0; i < 400 && m_ph != M_PLAY; i++) begin
      if (m_ph == M_CLEAR) frame_tick_i = 1; else start_i = 1;
      step();
    end
    check("reach_play", 32'(m_ph), 32'(M_PLAY));
    kill(4'd7);
    #2 reset_i = 1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk_i);
    reset_i = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
